// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 Hz timing constants, coordinate/colour widths
// and small helpers used by the VGA timing generator and its axis counters.
package vga_pkg;

  // Counter and colour widths
  localparam int COORD_W = 10;
  localparam int COLOR_W = 4;

  // Horizontal timing, in pixel clocks
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing, in lines
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    color_t r;
    color_t g;
    color_t b;
  } rgb_t;

  // Inclusive window test on a coordinate
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical). Counts
// 0..TOTAL-1 while enable_i is high and wraps to 0 after the last position.
// Ports:
//   clk25            pixel clock
//   rst              asynchronous active-high reset
//   enable_i         advance the count this clock
//   count_o          current position on the axis
//   wrap_o           high in the cycle the count goes from TOTAL-1 to 0
//   active_visible_o count is inside the visible region
//   in_sync_o        count is inside the sync pulse window
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic               clk25,
  input  logic               rst,
  input  logic               enable_i,
  output logic [COORD_W-1:0] count_o,
  output logic               wrap_o,
  output logic               active_visible_o,
  output logic               in_sync_o
);

  localparam int     TOTAL   = VISIBLE + FRONT + SYNC + BACK;
  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t VIS_END = coord_t'(VISIBLE);
  localparam coord_t SYNC_LO = coord_t'(VISIBLE + FRONT);
  localparam coord_t SYNC_HI = coord_t'(VISIBLE + FRONT + SYNC - 1);

  coord_t count_q;
  coord_t count_d;

  // Next position: hold, step by one, or wrap after the last position
  always_comb begin
    count_d = count_q;
    if (enable_i) begin
      if (count_q == LAST) begin
        count_d = coord_t'(0);
      end else begin
        count_d = count_q + coord_t'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Position register
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      count_q <= coord_t'(0);
    end else begin
      count_q <= count_d;
    end
  end

  // Wrap is qualified by enable so a cascaded axis steps once per wrap
  assign wrap_o           = enable_i && (count_q == LAST);
  assign active_visible_o = (count_q < VIS_END);
  assign in_sync_o        = in_window(count_q, SYNC_LO, SYNC_HI);
  assign count_o          = count_q;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 Hz raster timing generator. Drives pixel
// coordinates to the game logic, takes back its combinational colour and
// registers colour, blanking and syncs in one aligned output stage.
// Ports:
//   clk25                 25 MHz pixel clock
//   rst                   asynchronous active-high reset
//   xpos, ypos            current pixel column / line
//   frame_tick            one-clock pulse at (0, V_VISIBLE)
//   frame_count           completed frames since reset, wrapping
//   red_in/green_in/blue_in  colour for the current xpos/ypos
//   vga_r/vga_g/vga_b     registered, blanked colour to the DAC
//   vga_hs, vga_vs        registered syncs, aligned with the colour
module vga_timing #(
  parameter int   H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int   H_FRONT     = vga_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BACK      = vga_pkg::H_BACK,
  parameter int   V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int   V_FRONT     = vga_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BACK      = vga_pkg::V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic                        clk25,
  input  logic                        rst,
  output logic [vga_pkg::COORD_W-1:0] xpos,
  output logic [vga_pkg::COORD_W-1:0] ypos,
  output logic                        frame_tick,
  output logic [15:0]                 frame_count,
  input  logic [vga_pkg::COLOR_W-1:0] red_in,
  input  logic [vga_pkg::COLOR_W-1:0] green_in,
  input  logic [vga_pkg::COLOR_W-1:0] blue_in,
  output logic [vga_pkg::COLOR_W-1:0] vga_r,
  output logic [vga_pkg::COLOR_W-1:0] vga_g,
  output logic [vga_pkg::COLOR_W-1:0] vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs
);

  import vga_pkg::*;

  localparam coord_t TICK_LINE = coord_t'(V_VISIBLE);

  coord_t      x_s;
  coord_t      y_s;
  logic        h_wrap_s;
  logic        v_wrap_s;
  logic        h_vis_s;
  logic        v_vis_s;
  logic        hs_act_s;
  logic        vs_act_s;

  rgb_t        rgb_q;
  rgb_t        rgb_d;
  logic        hs_q;
  logic        hs_d;
  logic        vs_q;
  logic        vs_d;
  logic [15:0] frame_count_q;
  logic [15:0] frame_count_d;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk25            (clk25),
    .rst              (rst),
    .enable_i         (1'b1),
    .count_o          (x_s),
    .wrap_o           (h_wrap_s),
    .active_visible_o (h_vis_s),
    .in_sync_o        (hs_act_s)
  );

  // The vertical axis steps once per line; its wrap marks the end of a frame
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk25            (clk25),
    .rst              (rst),
    .enable_i         (h_wrap_s),
    .count_o          (y_s),
    .wrap_o           (v_wrap_s),
    .active_visible_o (v_vis_s),
    .in_sync_o        (vs_act_s)
  );

  // Next-state of the output stage: colour is forced to zero outside the
  // visible area regardless of what the game logic supplies
  always_comb begin
    rgb_d         = '0;
    hs_d          = ~SYNC_ACTIVE;
    vs_d          = ~SYNC_ACTIVE;
    frame_count_d = frame_count_q;
    if (h_vis_s && v_vis_s) begin
      rgb_d = '{r: red_in, g: green_in, b: blue_in};
    end else begin
      rgb_d = '0;
    end
    if (hs_act_s) begin
      hs_d = SYNC_ACTIVE;
    end else begin
      hs_d = ~SYNC_ACTIVE;
    end
    if (vs_act_s) begin
      vs_d = SYNC_ACTIVE;
    end else begin
      vs_d = ~SYNC_ACTIVE;
    end
    if (v_wrap_s) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Aligned output stage and frame counter
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      rgb_q         <= '0;
      hs_q          <= ~SYNC_ACTIVE;
      vs_q          <= ~SYNC_ACTIVE;
      frame_count_q <= 16'd0;
    end else begin
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign xpos        = x_s;
  assign ypos        = y_s;
  assign frame_tick  = (x_s == coord_t'(0)) && (y_s == TICK_LINE);
  assign frame_count = frame_count_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;

endmodule
